change_dispense_ctrl: RTL and testbench

- Sequences the coin-eject mechanism that returns change after a vend or cancel.
- Accepts a change amount from the vending FSM and pays it out greedily from three coin tubes (5/10/20), one coin at a time, with an ack handshake per coin.
- Tracks per-tube inventory, handles refill, and reports shortfall, jam and low-coin status.

---
 rtl/change_dispense_if.sv | 25 ++
 rtl/change_dispense_ctrl.sv | 176 +++++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispense_if.sv
// Change-dispense handshake bundle: vending-FSM request, coin-eject mechanism
// handshake, refill strobe and status back to the host.
interface change_dispense_if;
  logic       change_req;
  logic [7:0] change_amt;
  logic       eject_ack;
  logic       refill;
  logic [1:0] refill_sel;
  logic [1:0] eject_coin;
  logic       change_busy;
  logic       change_done;
  logic [7:0] shortfall;
  logic       jam;
  logic [2:0] low_coin;

  modport master (
    output change_req, change_amt, eject_ack, refill, refill_sel,
    input  eject_coin, change_busy, change_done, shortfall, jam, low_coin
  );

  modport slave (
    input  change_req, change_amt, eject_ack, refill, refill_sel,
    output eject_coin, change_busy, change_done, shortfall, jam, low_coin
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy change payout from three coin tubes (5/10/20) with per-coin ack
// handshake, ack-timeout jam detection, tube inventory and refill.
module change_dispense_ctrl #(
  parameter int unsigned TUBE_DEPTH  = 15,
  parameter int unsigned INIT_FILL   = 10,
  parameter int unsigned LOW_THRESH  = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  change_dispense_if.slave  bus
);

  localparam int unsigned CW = $clog2(TUBE_DEPTH + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned NT = 3;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_FINISH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NT-1:0][CW-1:0] r_cnt;
  logic [NT-1:0][CW-1:0] w_cnt_nxt;
  logic [7:0]            r_remaining;
  logic [7:0]            w_remaining_nxt;
  logic [TW-1:0]         r_tmo;
  logic [TW-1:0]         w_tmo_nxt;
  logic [1:0]            r_coin;
  logic [1:0]            w_coin_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_jam;
  logic                  w_jam_nxt;
  logic [7:0]            r_shortfall;
  logic [7:0]            w_shortfall_nxt;
  logic [1:0]            w_pick;
  logic                  w_ack_take;
  logic                  w_timeout;

  // Coin code to currency value; code = tube index + 1
  function automatic logic [7:0] coin_val(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      2'b01:   v = 8'd5;
      2'b10:   v = 8'd10;
      2'b11:   v = 8'd20;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Largest coin that fits the remainder and whose tube is not empty
  always_comb begin
    w_pick = 2'b00;
    if (r_remaining >= 8'd20 && r_cnt[2] != '0)
      w_pick = 2'b11;
    else if (r_remaining >= 8'd10 && r_cnt[1] != '0)
      w_pick = 2'b10;
    else if (r_remaining >= 8'd5 && r_cnt[0] != '0)
      w_pick = 2'b01;
  end

  assign w_ack_take = (r_state == S_EJECT) && bus.eject_ack;
  assign w_timeout  = (r_state == S_EJECT) && !bus.eject_ack &&
                      (r_tmo == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.change_req) w_state_nxt = S_SELECT;
      S_SELECT: w_state_nxt = (w_pick != 2'b00) ? S_EJECT : S_FINISH;
      S_EJECT: begin
        if (w_ack_take)     w_state_nxt = S_SELECT;
        else if (w_timeout) w_state_nxt = S_FINISH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the payout datapath and registered outputs
  always_comb begin
    w_remaining_nxt = r_remaining;
    w_tmo_nxt       = r_tmo;
    w_coin_nxt      = r_coin;
    w_jam_nxt       = r_jam;
    w_shortfall_nxt = r_shortfall;
    case (r_state)
      S_IDLE: begin
        if (bus.change_req) begin
          w_remaining_nxt = bus.change_amt;
          w_jam_nxt       = 1'b0;
          w_shortfall_nxt = 8'd0;
          w_tmo_nxt       = '0;
          w_coin_nxt      = 2'b00;
        end
      end
      S_SELECT: begin
        w_tmo_nxt = '0;
        if (w_pick != 2'b00) w_coin_nxt      = w_pick;
        else                 w_shortfall_nxt = r_remaining;
      end
      S_EJECT: begin
        if (w_ack_take) begin
          w_remaining_nxt = r_remaining - coin_val(r_coin);
          w_tmo_nxt       = '0;
          w_coin_nxt      = 2'b00;
        end else if (w_timeout) begin
          w_jam_nxt       = 1'b1;
          w_shortfall_nxt = r_remaining;
          w_tmo_nxt       = '0;
          w_coin_nxt      = 2'b00;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Tube inventory: a same-edge refill and ejection of one tube cancel out
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < int'(NT); i++) begin
      logic inc;
      logic dec;
      inc = bus.refill && (bus.refill_sel == 2'(i + 1));
      dec = w_ack_take && (r_coin == 2'(i + 1));
      if (inc && !dec) begin
        if (r_cnt[i] != CW'(TUBE_DEPTH)) w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end else if (dec && !inc) begin
        w_cnt_nxt[i] = r_cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NT); i++) r_cnt[i] <= CW'(INIT_FILL);
      r_remaining <= 8'd0;
      r_tmo       <= '0;
      r_coin      <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_jam       <= 1'b0;
      r_shortfall <= 8'd0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_remaining <= w_remaining_nxt;
      r_tmo       <= w_tmo_nxt;
      r_coin      <= w_coin_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_FINISH);
      r_jam       <= w_jam_nxt;
      r_shortfall <= w_shortfall_nxt;
    end
  end

  assign bus.eject_coin  = r_coin;
  assign bus.change_busy = r_busy;
  assign bus.change_done = r_done;
  assign bus.shortfall   = r_shortfall;
  assign bus.jam         = r_jam;

  // Low-coin flags follow the count registers directly
  always_comb begin
    for (int i = 0; i < int'(NT); i++)
      bus.low_coin[i] = (r_cnt[i] <= CW'(LOW_THRESH));
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: vector table of payouts plus
// hand-written jam, refill and mid-payout reset sequences.
module tb_change_dispense_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  change_dispense_if bus_if ();

  change_dispense_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  amt;
    int          n;
    logic [15:0] seq;
    logic [7:0]  sf;
  } vec_t;

  vec_t       vecs[7];
  logic [1:0] got_q[$];
  int         got_done;
  logic [7:0] got_sf;
  logic       got_jam;
  logic       got_timeout;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.change_req = 1'b0;
    bus_if.change_amt = 8'd0;
    bus_if.eject_ack  = 1'b0;
    bus_if.refill     = 1'b0;
    bus_if.refill_sel = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Request a payout and ack every coin ack_dly cycles after it appears
  task automatic run_payout(input logic [7:0] amt, input int ack_dly);
    got_q.delete();
    got_done    = 0;
    got_sf      = 8'hxx;
    got_jam     = 1'bx;
    got_timeout = 1'b1;
    bus_if.change_req = 1'b1;
    bus_if.change_amt = amt;
    tick();
    bus_if.change_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus_if.change_done) begin
        got_done++;
        got_sf  = bus_if.shortfall;
        got_jam = bus_if.jam;
      end
      if (!bus_if.change_busy) begin
        got_timeout = 1'b0;
        break;
      end
      if (bus_if.eject_coin != 2'b00) begin
        got_q.push_back(bus_if.eject_coin);
        repeat (ack_dly) tick();
        bus_if.eject_ack = 1'b1;
        tick();
        bus_if.eject_ack = 1'b0;
      end else begin
        tick();
      end
    end
    check("payout_completes", int'(got_timeout), 0);
  endtask

  task automatic check_coins(input string nm, input int n, input logic [15:0] seq);
    logic [1:0] exp_c;
    check({nm, "_ncoins"}, got_q.size(), n);
    for (int k = 0; k < n; k++) begin
      exp_c = seq[2*k +: 2];
      if (k < got_q.size()) check({nm, "_coin"}, int'(got_q[k]), int'(exp_c));
      else                  check({nm, "_coin_missing"}, -1, int'(exp_c));
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;

    vecs[0] = '{8'd35,  3, 16'h001B, 8'd0};
    vecs[1] = '{8'd7,   1, 16'h0001, 8'd2};
    vecs[2] = '{8'd0,   0, 16'h0000, 8'd0};
    vecs[3] = '{8'd43,  2, 16'h000F, 8'd3};
    vecs[4] = '{8'd18,  2, 16'h0006, 8'd3};
    vecs[5] = '{8'd100, 5, 16'h03FF, 8'd0};
    vecs[6] = '{8'd30,  2, 16'h000B, 8'd0};

    do_reset();
    check("rst_eject_coin", int'(bus_if.eject_coin), 0);
    check("rst_busy", int'(bus_if.change_busy), 0);
    check("rst_done", int'(bus_if.change_done), 0);
    check("rst_shortfall", int'(bus_if.shortfall), 0);
    check("rst_jam", int'(bus_if.jam), 0);
    check("rst_low_coin", int'(bus_if.low_coin), 0);
    for (int i = 0; i < 3; i++) check("rst_count", int'(dut.r_cnt[i]), 10);

    // Greedy table: counts carry over from one vector to the next
    for (int v = 0; v < 7; v++) begin
      run_payout(vecs[v].amt, 2);
      check_coins($sformatf("vec%0d", v), vecs[v].n, vecs[v].seq);
      check($sformatf("vec%0d_done", v), got_done, 1);
      check($sformatf("vec%0d_shortfall", v), int'(got_sf), int'(vecs[v].sf));
      check($sformatf("vec%0d_jam", v), int'(got_jam), 0);
      if (v == 0) begin
        for (int i = 0; i < 3; i++) check("g35_count", int'(dut.r_cnt[i]), 9);
        check("g35_low_coin", int'(bus_if.low_coin), 0);
      end
    end
    check("tbl_count5", int'(dut.r_cnt[0]), 7);
    check("tbl_count10", int'(dut.r_cnt[1]), 7);
    check("tbl_count20", int'(dut.r_cnt[2]), 1);
    check("tbl_low_coin", int'(bus_if.low_coin), 3'b100);

    // Drain the 20 tube then fall back to tens
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      run_payout(8'd20, 2);
      check_coins("drain", 1, 16'h0003);
      check("drain_low_coin", int'(bus_if.low_coin), (10 - k <= 2) ? 3'b100 : 3'b000);
    end
    check("drain_count20", int'(dut.r_cnt[2]), 0);
    run_payout(8'd20, 2);
    check_coins("empty20", 2, 16'h000A);
    check("empty20_shortfall", int'(got_sf), 0);
    check("empty20_count10", int'(dut.r_cnt[1]), 8);

    // Jam: no ack ever arrives
    do_reset();
    bus_if.change_req = 1'b1;
    bus_if.change_amt = 8'd10;
    tick();
    bus_if.change_req = 1'b0;
    check("jam_busy", int'(bus_if.change_busy), 1);
    tick();
    n = 0;
    while (bus_if.eject_coin == 2'b10 && n < 100) begin
      n++;
      tick();
    end
    check("jam_eject_cycles", n, 15);
    check("jam_done", int'(bus_if.change_done), 1);
    check("jam_flag", int'(bus_if.jam), 1);
    check("jam_shortfall", int'(bus_if.shortfall), 10);
    check("jam_count10", int'(dut.r_cnt[1]), 10);
    tick();
    check("jam_done_one_cycle", int'(bus_if.change_done), 0);
    check("jam_held", int'(bus_if.jam), 1);
    check("jam_shortfall_held", int'(bus_if.shortfall), 10);
    run_payout(8'd5, 1);
    check("jam_cleared", int'(bus_if.jam), 0);
    check("jam_clear_shortfall", int'(got_sf), 0);
    check_coins("after_jam", 1, 16'h0001);

    // Refill saturation, refill-vs-ack cancel, request ignored while busy
    do_reset();
    bus_if.refill     = 1'b1;
    bus_if.refill_sel = 2'b01;
    repeat (6) tick();
    bus_if.refill = 1'b0;
    check("refill_sat_count5", int'(dut.r_cnt[0]), 15);
    bus_if.change_req = 1'b1;
    bus_if.change_amt = 8'd20;
    tick();
    bus_if.change_req = 1'b0;
    tick();
    check("rf_eject20", int'(bus_if.eject_coin), 3);
    bus_if.change_req = 1'b1;
    bus_if.change_amt = 8'd50;
    tick();
    bus_if.change_req = 1'b0;
    check("rf_coin_held", int'(bus_if.eject_coin), 3);
    bus_if.eject_ack  = 1'b1;
    bus_if.refill     = 1'b1;
    bus_if.refill_sel = 2'b11;
    tick();
    bus_if.eject_ack = 1'b0;
    bus_if.refill    = 1'b0;
    check("rf_cancel_count20", int'(dut.r_cnt[2]), 10);
    check("rf_coin_dropped", int'(bus_if.eject_coin), 0);
    tick();
    check("rf_done", int'(bus_if.change_done), 1);
    check("rf_shortfall", int'(bus_if.shortfall), 0);
    tick();
    check("rf_idle", int'(bus_if.change_busy), 0);
    tick();
    check("rf_req_not_queued", int'(bus_if.change_busy), 0);

    // Reset in the middle of an ejection
    run_payout(8'd20, 2);
    check("mr_count20_pre", int'(dut.r_cnt[2]), 9);
    bus_if.change_req = 1'b1;
    bus_if.change_amt = 8'd20;
    tick();
    bus_if.change_req = 1'b0;
    tick();
    check("mr_eject20", int'(bus_if.eject_coin), 3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_coin_async", int'(bus_if.eject_coin), 0);
    check("mr_busy_async", int'(bus_if.change_busy), 0);
    check("mr_count20", int'(dut.r_cnt[2]), 10);
    #2 rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus_if.change_done || bus_if.change_busy) n++;
    end
    check("mr_no_done", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
